fp_div_iter: RTL and testbench

Parametrised iterative IEEE-754 floating-point divider; next generation of the FPU's 32-bit divide unit. Computes a_i / b_i for any (EXP_W, MAN_W) format using a radix-2 restoring mantissa divider. Adds special-operand handling, guard/round/sticky rounding, exception flags and an abort path. Sits in the FPU beside the add/mul units and is driven by the FPU issue logic through a start/ready/valid handshake.

---
 rtl/fp_div_iter_if.sv | 28 ++
 rtl/fp_div_iter.sv | 218 +++++++++++++++++++++
 tb/tb_fp_div_iter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_div_iter_if.sv
// fp_div_iter_if: start/ready/valid handshake and data bus of the iterative
// floating-point divider. The issue logic drives the master side; the divider
// is the slave.
interface fp_div_iter_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start_i;
    logic         abort_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [W-1:0] q_o;
    logic [4:0]   flags_o;
    logic         valid_o;
    logic         ready_o;

    modport master (
        output start_i, abort_i, a_i, b_i,
        input  q_o, flags_o, valid_o, ready_o
    );

    modport slave (
        input  start_i, abort_i, a_i, b_i,
        output q_o, flags_o, valid_o, ready_o
    );
endinterface

// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative IEEE-754 divider for any (EXP_W, MAN_W) format.
// Radix-2 restoring mantissa division, one quotient bit per clock, with
// special-operand handling, flush-to-zero, exception flags and abort.
// Optional feature macro: FP_DIV_ROUND_EN selects round-to-nearest-even;
// when undefined the result is truncated (inexact is still reported).
// flags_o = {invalid, div_by_zero, overflow, underflow, inexact}.
module fp_div_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic          clk_i,
    input logic          rst_i,
    fp_div_iter_if.slave bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EW2   = EXP_W + 2;
    localparam int CNT_W = $clog2(MAN_W + 4);

    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(MAN_W + 2);
    localparam logic signed [EW2-1:0] BIAS     = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] EMAX_S   = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] ZERO_S   = '0;
    localparam logic [W-1:0]          QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, ITER, NORM, DONE} state_t;

    state_t                state;
    logic [W-1:0]          a_reg, b_reg;
    logic [CNT_W-1:0]      cnt;
    logic [MAN_W+1:0]      rem;
    logic [MAN_W:0]        div;
    logic [MAN_W+2:0]      quo;
    logic signed [EW2-1:0] exp_r;
    logic [W-1:0]          q_reg;
    logic [4:0]            flags_reg;
    logic                  valid_reg, ready_reg;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             res_sign;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
    logic [W-1:0]     spec_q, norm_q;
    logic [4:0]       spec_f, norm_f;
    logic             ge;
    logic [MAN_W:0]   diff;
    logic [MAN_W+1:0] rem_next;
    logic [MAN_W-1:0] frac_pre;
    logic [MAN_W:0]   frac_sum;
    logic             guard, rnd, sticky, inexact;
    logic signed [EW2-1:0] e_norm, e_fin;
`ifdef FP_DIV_ROUND_EN
    logic             inc;
`endif

    assign ea       = a_reg[W-2:MAN_W];
    assign eb       = b_reg[W-2:MAN_W];
    assign fa       = a_reg[MAN_W-1:0];
    assign fb       = b_reg[MAN_W-1:0];
    assign res_sign = a_reg[W-1] ^ b_reg[W-1];

    // Subnormals have a zero exponent and are therefore treated as zero.
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (ea == '1) && (fa == '0);
    assign b_inf   = (eb == '1) && (fb == '0);
    assign a_nan   = (ea == '1) && (fa != '0);
    assign b_nan   = (eb == '1) && (fb != '0);
    assign special = a_zero || b_zero || (ea == '1) || (eb == '1);

    // Result for operands that bypass the mantissa divider, in priority order.
    always_comb begin
        spec_q = '0;
        spec_f = '0;
        if (a_nan || b_nan) begin
            spec_q = QNAN;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_q = QNAN;
            spec_f = 5'b10000;
        end else if (a_inf) begin
            spec_q = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_zero) begin
            spec_q = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_f = 5'b01000;
        end else begin
            spec_q = {res_sign, {(W-1){1'b0}}};
        end
    end

    // One restoring-division step; the shifted remainder always fits MAN_W+2 bits.
    always_comb begin
        ge       = (rem >= {1'b0, div});
        diff     = rem[MAN_W:0] - div;
        rem_next = ge ? {diff, 1'b0} : {rem[MAN_W:0], 1'b0};
    end

    // Normalise, round, and range-check the raw quotient bits.
    always_comb begin
        if (quo[MAN_W+2]) begin
            frac_pre = quo[MAN_W+1:2];
            guard    = quo[1];
            rnd      = quo[0];
            e_norm   = exp_r;
        end else begin
            frac_pre = quo[MAN_W:1];
            guard    = quo[0];
            rnd      = 1'b0;
            e_norm   = exp_r - EW2'(1);
        end
        sticky  = |rem;
        inexact = guard | rnd | sticky;
`ifdef FP_DIV_ROUND_EN
        inc      = guard & (rnd | sticky | frac_pre[0]);
        frac_sum = {1'b0, frac_pre} + {{MAN_W{1'b0}}, inc};
`else
        frac_sum = {1'b0, frac_pre};
`endif
        e_fin  = e_norm + {{(EW2-1){1'b0}}, frac_sum[MAN_W]};
        norm_q = {res_sign, e_fin[EXP_W-1:0], frac_sum[MAN_W-1:0]};
        norm_f = {4'b0000, inexact};
        if (e_fin >= EMAX_S) begin
            norm_q = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            norm_f = 5'b00101;
        end else if (e_fin <= ZERO_S) begin
            norm_q = {res_sign, {(W-1){1'b0}}};
            norm_f = 5'b00011;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            cnt       <= '0;
            rem       <= '0;
            div       <= '0;
            quo       <= '0;
            exp_r     <= '0;
            q_reg     <= '0;
            flags_reg <= '0;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            valid_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        a_reg     <= bus.a_i;
                        b_reg     <= bus.b_i;
                        ready_reg <= 1'b0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (bus.abort_i) begin
                        ready_reg <= 1'b1;
                        state     <= IDLE;
                    end else if (special) begin
                        state <= DONE;
                    end else begin
                        rem   <= {2'b01, fa};
                        div   <= {1'b1, fb};
                        quo   <= '0;
                        cnt   <= '0;
                        exp_r <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
                        state <= ITER;
                    end
                end
                ITER: begin
                    if (bus.abort_i) begin
                        cnt       <= '0;
                        ready_reg <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        quo <= {quo[MAN_W+1:0], ge};
                        rem <= rem_next;
                        if (cnt == LAST_BIT) begin
                            cnt   <= '0;
                            state <= NORM;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                NORM: begin
                    if (bus.abort_i) begin
                        ready_reg <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        q_reg     <= norm_q;
                        flags_reg <= norm_f;
                        valid_reg <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (special) begin
                        q_reg     <= spec_q;
                        flags_reg <= spec_f;
                        valid_reg <= 1'b1;
                    end
                    ready_reg <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    ready_reg <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.q_o     = q_reg;
    assign bus.flags_o = flags_reg;
    assign bus.valid_o = valid_reg;
    assign bus.ready_o = ready_reg;
endmodule

// File: tb/tb_fp_div_iter.sv
// tb_fp_div_iter: scoreboard bench for the binary32 build of fp_div_iter.
// Expected results come from an arithmetic reference model (one exact integer
// division plus remainder-based rounding) and are queued at issue time.
module tb_fp_div_iter;
    typedef struct {
        logic [31:0] q;
        logic [4:0]  f;
        int          issue;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    fp_div_iter_if #(.EXP_W(8), .MAN_W(23)) bus();

    fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: exact quotient scaled to 24 significant bits, rounded from the remainder.
    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b, input int issue);
        exp_t   r;
        int     ea = int'(a[30:23]);
        int     eb = int'(b[30:23]);
        longint fa = longint'(a[22:0]);
        longint fb = longint'(b[22:0]);
        bit     az = (ea == 0);
        bit     bz = (eb == 0);
        bit     ainf = (ea == 255) && (fa == 0);
        bit     binf = (eb == 255) && (fb == 0);
        bit     anan = (ea == 255) && (fa != 0);
        bit     bnan = (eb == 255) && (fb != 0);
        bit     s = a[31] ^ b[31];
        longint ma, mb, num, mant, rem;
        int     e;
        r.issue = issue;
        r.lat   = 2;
        r.f     = 5'b0;
        if (anan || bnan) begin
            r.q = 32'h7FC00000;
        end else if ((az && bz) || (ainf && binf)) begin
            r.q = 32'h7FC00000;
            r.f = 5'b10000;
        end else if (ainf) begin
            r.q = {s, 8'hFF, 23'h0};
        end else if (bz) begin
            r.q = {s, 8'hFF, 23'h0};
            r.f = 5'b01000;
        end else if (az || binf) begin
            r.q = {s, 31'h0};
        end else begin
            r.lat = 28;
            ma = fa + 64'd8388608;
            mb = fb + 64'd8388608;
            e  = ea - eb + 127;
            if (ma >= mb) begin
                num = ma * 64'd8388608;
            end else begin
                num = ma * 64'd16777216;
                e   = e - 1;
            end
            mant = num / mb;
            rem  = num % mb;
`ifdef FP_DIV_ROUND_EN
            if ((2 * rem > mb) || ((2 * rem == mb) && mant[0])) mant = mant + 1;
            if (mant == 64'd16777216) begin
                mant = mant / 2;
                e    = e + 1;
            end
`endif
            if (e >= 255) begin
                r.q = {s, 8'hFF, 23'h0};
                r.f = 5'b00101;
            end else if (e <= 0) begin
                r.q = {s, 31'h0};
                r.f = 5'b00011;
            end else begin
                r.q = {s, 8'(e), 23'(mant)};
                r.f = {4'b0, rem != 0};
            end
        end
        return r;
    endfunction

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_valid: got q=%h, expected no completion", bus.q_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("q", 64'(bus.q_o), 64'(e.q));
                check_output("flags", 64'(bus.flags_o), 64'(e.f));
                check_output("latency", 64'(cyc - e.issue), 64'(e.lat));
            end
        end
    end

    // Issue one operation when the divider is ready; optionally queue its expectation.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input bit track);
        int n = 0;
        while (bus.ready_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_output("ready_timeout", 64'(bus.ready_o), 64'd1);
        bus.a_i     = a;
        bus.b_i     = b;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        if (track) sb.push_back(ref_div(a, b, cyc));
        check_output("ready_fall", 64'(bus.ready_o), 64'd0);
    endtask

    // Wait, bounded, until every queued expectation has been consumed.
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_output("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v = $urandom;
        int k = $urandom_range(0, 9);
        if (k == 0) v[30:23] = 8'h00;
        else if (k == 1) v[30:23] = 8'hFF;
        else if (k >= 4) v[30:23] = 8'($urandom_range(110, 144));
        if ($urandom_range(0, 5) == 0) v[22:0] = 23'h0;
        return v;
    endfunction

    initial begin
        #(10 * 20000);
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] held;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("reset_q", 64'(bus.q_o), 64'd0);
        check_output("reset_flags", 64'(bus.flags_o), 64'd0);
        check_output("reset_valid", 64'(bus.valid_o), 64'd0);
        check_output("reset_ready", 64'(bus.ready_o), 64'd1);

        // 6.0 / 2.0
        apply_stimulus(32'h40C00000, 32'h40000000, 1'b1);
        drain();
        check_output("six_by_two", 64'(bus.q_o), 64'h40400000);

        // 1 / 3
        apply_stimulus(32'h3F800000, 32'h40400000, 1'b1);
        drain();
`ifdef FP_DIV_ROUND_EN
        check_output("one_third", 64'(bus.q_o), 64'h3EAAAAAB);
`else
        check_output("one_third", 64'(bus.q_o), 64'h3EAAAAAA);
`endif
        check_output("one_third_flags", 64'(bus.flags_o), 64'h01);

        // Special operands and range limits
        apply_stimulus(32'h3F800000, 32'h00000000, 1'b1);
        drain();
        check_output("div_zero", 64'({bus.flags_o, bus.q_o}), 64'({5'b01000, 32'h7F800000}));
        apply_stimulus(32'h00000000, 32'h00000000, 1'b1);
        drain();
        check_output("zero_zero", 64'({bus.flags_o, bus.q_o}), 64'({5'b10000, 32'h7FC00000}));
        apply_stimulus(32'hFF800000, 32'h40000000, 1'b1);
        apply_stimulus(32'h7F000000, 32'h3F000000, 1'b1);
        drain();
        check_output("overflow", 64'({bus.flags_o, bus.q_o}), 64'({5'b00101, 32'h7F800000}));
        apply_stimulus(32'h00800000, 32'h40000000, 1'b1);
        drain();
        check_output("underflow", 64'({bus.flags_o, bus.q_o}), 64'({5'b00011, 32'h00000000}));

        // Abort five cycles after start, then an immediate new operation
        held = bus.q_o;
        apply_stimulus(32'h40C00000, 32'h40000000, 1'b0);
        repeat (4) @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        check_output("abort_ready", 64'(bus.ready_o), 64'd1);
        check_output("abort_valid", 64'(bus.valid_o), 64'd0);
        check_output("abort_q_hold", 64'(bus.q_o), 64'(held));
        apply_stimulus(32'h41200000, 32'h40A00000, 1'b1);
        drain();

        // start_i held during ITER must not launch another operation
        apply_stimulus(32'h42C80000, 32'h41200000, 1'b1);
        bus.a_i     = 32'h3F800000;
        bus.b_i     = 32'h00000000;
        bus.start_i = 1'b1;
        repeat (10) @(negedge clk);
        bus.start_i = 1'b0;
        drain();

        // Reset in the middle of ITER
        apply_stimulus(32'h40C00000, 32'h40400000, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("midrst_q", 64'(bus.q_o), 64'd0);
        check_output("midrst_flags", 64'(bus.flags_o), 64'd0);
        check_output("midrst_valid", 64'(bus.valid_o), 64'd0);
        check_output("midrst_ready", 64'(bus.ready_o), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        apply_stimulus(32'hC0490FDB, 32'h402DF854, 1'b1);
        drain();

        // Randomised back-to-back traffic
        for (int i = 0; i < 150; i++) begin
            apply_stimulus(rand_operand(), rand_operand(), 1'b1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
